ahb_lite_slave_controller: RTL and testbench



---
 rtl/ahb_lite_slave_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_ahb_lite_slave_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_slave_controller.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_controller
//   AHB-Lite register front end for the Triple-DES core. The bus master
//   programs control, data and three 64-bit keys. A KEY3 write triggers a
//   one-cycle start pulse to the core, and the core's result is captured into
//   a read-only RESULT register.
//
//   Zero-wait-state, single-cycle slave on a 64-bit data bus. HRESP is
//   always OKAY.
//
//   Register map (word offset = HADDR - BASE_ADDR, full 32-bit compare):
//     0 CTRL   (bit0 = encryptionType, other bits read 0)
//     1 DATA
//     2 KEY1
//     3 KEY2
//     4 KEY3   (a committed write pulses enable on the next cycle)
//     5 RESULT (read-only; loaded from outputData when outputEnable is high)
//   Any other offset drops writes and reads back 0.
//
//   Build option:
//     AHB_HTRANS_CHECK_EN - when defined, an address phase is accepted only if
//                           HTRANS[1] = 1 (NONSEQ/SEQ). IDLE and BUSY are
//                           ignored. When undefined, HTRANS is not looked at.
// ---------------------------------------------------------------------------
module ahb_lite_slave_controller #(
    parameter logic [31:0] BASE_ADDR = 32'hAAAAAAA0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HADDR,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HRESP,
    input  logic        outputEnable,
    input  logic [63:0] outputData,
    output logic        enable,
    output logic        encryptionType,
    output logic [63:0] data,
    output logic [63:0] key1,
    output logic [63:0] key2,
    output logic [63:0] key3
);

    // Decoded register target carried from the address phase into the data phase
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_DATA   = 3'd1,
        REG_KEY1   = 3'd2,
        REG_KEY2   = 3'd3,
        REG_KEY3   = 3'd4,
        REG_RESULT = 3'd5,
        REG_NONE   = 3'd7
    } reg_sel_e;

    // Full 32-bit decode. Anything outside the six-word window maps to REG_NONE
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        logic [31:0] offset_v;
        reg_sel_e    sel_v;
        offset_v = addr - BASE_ADDR;
        case (offset_v)
            32'd0:   sel_v = REG_CTRL;
            32'd1:   sel_v = REG_DATA;
            32'd2:   sel_v = REG_KEY1;
            32'd3:   sel_v = REG_KEY2;
            32'd4:   sel_v = REG_KEY3;
            32'd5:   sel_v = REG_RESULT;
            default: sel_v = REG_NONE;
        endcase
        return sel_v;
    endfunction

    // Pipeline registers (address phase -> data phase)
    logic        valid_r;
    logic        write_r;
    reg_sel_e    sel_r;

    // Programmable state
    logic        ctrl_r;
    logic [63:0] data_r;
    logic [63:0] key1_r;
    logic [63:0] key2_r;
    logic [63:0] key3_r;
    logic [63:0] result_r;
    logic        enable_r;

    // Next-state values
    logic        xfer_req_s;
    logic        wr_commit_s;
    logic        ctrl_nxt_s;
    logic [63:0] data_nxt_s;
    logic [63:0] key1_nxt_s;
    logic [63:0] key2_nxt_s;
    logic [63:0] key3_nxt_s;
    logic [63:0] result_nxt_s;
    logic        enable_nxt_s;
    logic [63:0] rdata_s;

    // Sideband inputs this slave never acts on (the name keeps lint quiet)
    logic        unused_s;
    assign unused_s = ^{HMASTLOCK, HBURST, HSIZE, HPROT, HTRANS};

    // Transfer qualifier for the address phase, optionally gated by HTRANS[1]
    always_comb begin
        xfer_req_s = 1'b0;
`ifdef AHB_HTRANS_CHECK_EN
        if (HSEL && HREADY && HTRANS[1]) begin
            xfer_req_s = 1'b1;
        end else begin
            xfer_req_s = 1'b0;
        end
`else
        if (HSEL && HREADY) begin
            xfer_req_s = 1'b1;
        end else begin
            xfer_req_s = 1'b0;
        end
`endif
    end

    // Address-phase capture: latch target, direction and valid for the next cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_r <= 1'b0;
            write_r <= 1'b0;
            sel_r   <= REG_NONE;
        end else if (xfer_req_s) begin
            valid_r <= 1'b1;
            write_r <= HWRITE;
            sel_r   <= decode_addr(HADDR);
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign wr_commit_s = valid_r & write_r;

    // Data-phase write decode, core start pulse and result capture
    always_comb begin
        ctrl_nxt_s   = ctrl_r;
        data_nxt_s   = data_r;
        key1_nxt_s   = key1_r;
        key2_nxt_s   = key2_r;
        key3_nxt_s   = key3_r;
        enable_nxt_s = 1'b0;
        if (wr_commit_s) begin
            case (sel_r)
                REG_CTRL: ctrl_nxt_s = HWDATA[0];
                REG_DATA: data_nxt_s = HWDATA;
                REG_KEY1: key1_nxt_s = HWDATA;
                REG_KEY2: key2_nxt_s = HWDATA;
                REG_KEY3: begin
                    key3_nxt_s   = HWDATA;
                    enable_nxt_s = 1'b1;
                end
                // RESULT is read-only; unmapped offsets drop the write
                default: begin
                    ctrl_nxt_s   = ctrl_r;
                    enable_nxt_s = 1'b0;
                end
            endcase
        end else begin
            enable_nxt_s = 1'b0;
        end
        // Core result has priority over anything the bus tries to do to RESULT
        if (outputEnable) begin
            result_nxt_s = outputData;
        end else begin
            result_nxt_s = result_r;
        end
    end

    // Register file and enable pulse state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_r   <= 1'b0;
            data_r   <= 64'd0;
            key1_r   <= 64'd0;
            key2_r   <= 64'd0;
            key3_r   <= 64'd0;
            result_r <= 64'd0;
            enable_r <= 1'b0;
        end else begin
            ctrl_r   <= ctrl_nxt_s;
            data_r   <= data_nxt_s;
            key1_r   <= key1_nxt_s;
            key2_r   <= key2_nxt_s;
            key3_r   <= key3_nxt_s;
            result_r <= result_nxt_s;
            enable_r <= enable_nxt_s;
        end
    end

    // Read-data mux: driven only while a valid read sits in the data phase
    always_comb begin
        rdata_s = 64'd0;
        if (valid_r && !write_r) begin
            case (sel_r)
                REG_CTRL:   rdata_s = {63'd0, ctrl_r};
                REG_DATA:   rdata_s = data_r;
                REG_KEY1:   rdata_s = key1_r;
                REG_KEY2:   rdata_s = key2_r;
                REG_KEY3:   rdata_s = key3_r;
                REG_RESULT: rdata_s = result_r;
                default:    rdata_s = 64'd0;
            endcase
        end else begin
            rdata_s = 64'd0;
        end
    end

    assign HRDATA         = rdata_s;
    assign HRESP          = 1'b0;
    assign enable         = enable_r;
    assign encryptionType = ctrl_r;
    assign data           = data_r;
    assign key1           = key1_r;
    assign key2           = key2_r;
    assign key3           = key3_r;

endmodule

// File: tb/tb_ahb_lite_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave_controller
//   Directed scenarios followed by randomized AHB-Lite traffic. Every cycle is
//   compared against a transaction-level reference model: a word array indexed
//   by offset, plus one pending data-phase transfer.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave_controller;

    localparam logic [31:0] BASE = 32'hAAAAAAA0;
`ifdef AHB_HTRANS_CHECK_EN
    localparam bit TRANS_CHECK = 1'b1;
`else
    localparam bit TRANS_CHECK = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        HREADY;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HRESP;
    logic        outputEnable;
    logic [63:0] outputData;
    logic        enable;
    logic        encryptionType;
    logic [63:0] data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;

    ahb_lite_slave_controller #(.BASE_ADDR(BASE)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .outputEnable(outputEnable), .outputData(outputData),
        .enable(enable), .encryptionType(encryptionType), .data(data),
        .key1(key1), .key2(key2), .key3(key3)
    );

    always #5 HCLK = ~HCLK;

    // Reference model: word store by offset, one outstanding transfer, start pulse
    logic [63:0] m_reg [0:5];
    bit          m_pend_v;
    bit          m_pend_w;
    logic [31:0] m_pend_off;
    bit          m_en;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 64'd0;
        m_pend_v   = 1'b0;
        m_pend_w   = 1'b0;
        m_pend_off = 32'd0;
        m_en       = 1'b0;
    endtask

    function automatic logic [63:0] m_read(input logic [31:0] off);
        if (off < 32'd6) return m_reg[off];
        return 64'd0;
    endfunction

    // One bus cycle: drive inputs, check outputs at negedge, advance model at posedge
    task automatic cycle(input bit rst, input bit sel, input bit rdy, input bit wr,
                         input logic [1:0] tr, input logic [31:0] addr,
                         input logic [63:0] wdata, input bit oe, input logic [63:0] od);
        logic [63:0] exp_rd;
        HRESET       = rst;
        HSEL         = sel;
        HREADY       = rdy;
        HWRITE       = wr;
        HTRANS       = tr;
        HADDR        = addr;
        HWDATA       = wdata;
        outputEnable = oe;
        outputData   = od;
        HMASTLOCK    = 1'($urandom);
        HBURST       = 3'($urandom);
        HSIZE        = 3'($urandom);
        HPROT        = 4'($urandom);
        @(negedge HCLK);
        exp_rd = (m_pend_v && !m_pend_w) ? m_read(m_pend_off) : 64'd0;
        chk("HRDATA", HRDATA, exp_rd);
        chk("enable", {63'd0, enable}, {63'd0, m_en});
        chk("encryptionType", {63'd0, encryptionType}, m_reg[0]);
        chk("data", data, m_reg[1]);
        chk("key1", key1, m_reg[2]);
        chk("key2", key2, m_reg[3]);
        chk("key3", key3, m_reg[4]);
        chk("HRESP", {63'd0, HRESP}, 64'd0);
        @(posedge HCLK);
        if (rst) begin
            m_reset();
        end else begin
            m_en = m_pend_v && m_pend_w && (m_pend_off == 32'd4);
            if (m_pend_v && m_pend_w && m_pend_off < 32'd5)
                m_reg[m_pend_off] = (m_pend_off == 32'd0) ? {63'd0, wdata[0]} : wdata;
            if (oe) m_reg[5] = od;
            m_pend_v   = sel && rdy && (!TRANS_CHECK || tr[1]);
            m_pend_w   = wr;
            m_pend_off = addr - BASE;
        end
        #1;
    endtask

    // Plain selected, ready, NONSEQ transfer
    task automatic bus(input bit wr, input logic [31:0] off, input logic [63:0] wdata);
        cycle(1'b0, 1'b1, 1'b1, wr, 2'b10, BASE + off, wdata, 1'b0, 64'd0);
    endtask

    // Idle cycle carrying data-phase write data for the previous transfer
    task automatic idle(input logic [63:0] wdata);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, wdata, 1'b0, 64'd0);
    endtask

    logic [63:0] snap_data;
    logic [63:0] snap_key1;
    logic [63:0] r_wd;
    logic [31:0] r_addr;

    initial begin
        m_reset();
        HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
        HMASTLOCK = 1'b0; HBURST = 3'd0; HSIZE = 3'd0; HPROT = 4'd0;
        HADDR = 32'd0; HWDATA = 64'd0; outputEnable = 1'b0; outputData = 64'd0;
        @(posedge HCLK);
        #1;
        // Reset state (the model holds all zeros)
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 64'd0, 1'b0, 64'd0);
        chk("rst_hrdata", HRDATA, 64'd0);
        chk("rst_enable", {63'd0, enable}, 64'd0);

        // Pipelined writes to CTRL, DATA, KEY1..KEY3
        bus(1'b1, 32'd0, 64'd0);
        bus(1'b1, 32'd1, 64'd1);
        bus(1'b1, 32'd2, 64'h1111111111111111);
        bus(1'b1, 32'd3, 64'h2222222222222222);
        bus(1'b1, 32'd4, 64'h3333333333333333);
        idle(64'h4444444444444444);
        chk("t2_enable_hi", {63'd0, enable}, 64'd1);
        chk("t2_enc", {63'd0, encryptionType}, 64'd1);
        chk("t2_data", data, 64'h1111111111111111);
        chk("t2_key1", key1, 64'h2222222222222222);
        chk("t2_key2", key2, 64'h3333333333333333);
        chk("t2_key3", key3, 64'h4444444444444444);
        idle(64'd0);
        chk("t2_enable_lo", {63'd0, enable}, 64'd0);

        // Rewrite KEY3 for a second pulse
        bus(1'b1, 32'd4, 64'd0);
        idle(64'h5555555555555555);
        chk("t3_enable_hi", {63'd0, enable}, 64'd1);
        chk("t3_key3", key3, 64'h5555555555555555);
        chk("t3_data", data, 64'h1111111111111111);
        idle(64'd0);
        chk("t3_enable_lo", {63'd0, enable}, 64'd0);

        // Result capture, then readback of RESULT
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 64'd0, 1'b1, 64'hDEADBEEFCAFEF00D);
        bus(1'b0, 32'd5, 64'd0);
        chk("t4_hrdata", HRDATA, 64'hDEADBEEFCAFEF00D);
        idle(64'd0);
        chk("t4_hrdata_idle", HRDATA, 64'd0);

        // A RESULT write alone is dropped; a colliding outputEnable wins
        bus(1'b1, 32'd5, 64'd0);
        idle(64'h0123456789ABCDEF);
        bus(1'b1, 32'd5, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, BASE + 32'd5, 64'hFFFFFFFFFFFFFFFF,
              1'b1, 64'h0F0F0F0F0F0F0F0F);
        chk("t4_result_collide", HRDATA, 64'h0F0F0F0F0F0F0F0F);
        idle(64'd0);

        // Unmapped address, deselected and not-ready writes change nothing
        snap_data = data;
        snap_key1 = key1;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 64'd0, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, BASE + 32'd1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, BASE + 32'd2, 64'hBBBBBBBBBBBBBBBB, 1'b0, 64'd0);
        idle(64'hCCCCCCCCCCCCCCCC);
        chk("t5_data", data, snap_data);
        chk("t5_key1", key1, snap_key1);
        chk("t5_hresp", {63'd0, HRESP}, 64'd0);

        // HTRANS qualifier: IDLE write applies only when the check is disabled
        snap_data = data;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, BASE + 32'd1, 64'd0, 1'b0, 64'd0);
        idle(64'h7777777777777777);
        chk("t6_idle_write", data, TRANS_CHECK ? snap_data : 64'h7777777777777777);
        bus(1'b1, 32'd1, 64'd0);
        idle(64'h8888888888888888);
        chk("t6_nonseq_write", data, 64'h8888888888888888);

        // Reset during a pending data phase discards it
        bus(1'b1, 32'd2, 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 64'h9999999999999999, 1'b0, 64'd0);
        chk("rst_mid_key1", key1, 64'd0);
        chk("rst_mid_data", data, 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            r_addr = ($urandom_range(0, 99) < 85) ? BASE + 32'($urandom_range(0, 7)) : $urandom;
            r_wd   = {$urandom, $urandom};
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 99) < 80),
                  ($urandom_range(0, 99) < 85),
                  1'($urandom),
                  2'($urandom),
                  r_addr,
                  r_wd,
                  ($urandom_range(0, 99) < 20),
                  {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
